fir_ch_sched: RTL and testbench
===============================

Name: fir_ch_sched

Overview:
- Time-multiplexes one shared FIR MAC core across NUM_CH audio channels.
- Latches per-channel sample-ready requests and grants them round-robin.
- For each grant, drives the core's `sequencing` window for exactly the required length, steers the sample/coefficient muxes via `ch_sel`, and captures the core's result into a per-channel output register with a valid pulse.

Parameters:
- NUM_COEFF, 1021, number of filter taps; the core needs `sequencing` high for NUM_COEFF+1 consecutive cycles.
- NUM_CH, 2, number of channels sharing the core (2..8).
- CH_W, 1, width of `ch_sel`; must equal max(1, clog2(NUM_CH)).
- CNT_W, 11, width of the run counter; must hold NUM_COEFF+1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- req  in  NUM_CH  per-channel one-cycle pulse: new sample available
- core_out  in  16  core filter result (core `smpl_out`)
- ovr_clr  in  1  clears all `overrun` bits
- sequencing  out  1  core run enable
- ch_sel  out  CH_W  channel currently owning the core (mux select)
- busy  out  1  high in any state other than IDLE
- dout  out  16*NUM_CH  per-channel filtered sample; channel k occupies bits [16k+15:16k]
- dout_vld  out  NUM_CH  one-cycle pulse when the corresponding dout slice updates
- overrun  out  NUM_CH  sticky: a request arrived while that channel was already pending

Behaviour:
- All state is registered. `rst` is sampled only on the clk rising edge (synchronous, active high).
- Reset values: sequencing=0, ch_sel=0, busy=0, dout=0, dout_vld=0, overrun=0, pending=0, round-robin pointer=0, state=IDLE.
- Reset mid-run: the FSM returns to IDLE at that edge and `sequencing` drops. No capture occurs and no dout_vld pulse is issued. Pending requests are discarded.
- Pending[k] is set on req[k]=1.
  - If pending[k] is already 1, set overrun[k]; pending stays 1.
  - If a grant clears pending[k] in the same cycle that req[k]=1, pending[k] ends at 1 and overrun is not set.
- `ovr_clr` clears `overrun` at that edge. When ovr_clr and a new overrun condition occur together, set wins.
- FSM states:
  - IDLE: if any pending bit is set, grant the lowest channel index at or after rr_ptr (wrapping modulo NUM_CH). On grant: load ch_sel, clear that pending bit, set rr_ptr = granted+1 mod NUM_CH, load cnt=0, go to RUN.
  - RUN: sequencing=1. cnt increments each cycle. When cnt==NUM_COEFF, go to DRAIN. Sequencing is therefore high for exactly NUM_COEFF+1 cycles.
  - DRAIN: sequencing=0 for one cycle; the core latches its result at the end of this cycle.
  - CAPT: at this edge, dout[ch_sel] <= core_out and dout_vld[ch_sel]=1 for one cycle. Go to IDLE.
- `sequencing` is a registered output, high exactly during RUN cycles.
- `ch_sel` is stable from the first RUN cycle through CAPT; it holds its last value while in IDLE.
- Throughput: one channel every NUM_COEFF+4 cycles, i.e. 1025 at the default, when requests are continuously pending.
- Latency: if req[k] pulses in cycle t while IDLE and nothing else is pending, `sequencing` first rises in cycle t+2 and dout_vld[k] pulses in cycle t+NUM_COEFF+5.
- Non-granted dout slices hold their value. Only one dout_vld bit is ever high at a time.
- cnt never exceeds NUM_COEFF. No wrap is possible for CNT_W >= clog2(NUM_COEFF+1).

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no req → sequencing=0, busy=0, dout=0, overrun=0 for 50 cycles.
- Single channel, default params: req[0] pulse at cycle 10 → sequencing high cycles 12..1033 (1022 cycles), ch_sel=0; model core_out=16'h1234 → dout[15:0]=16'h1234, dout_vld=2'b01 at cycle 1036 only.
- Round-robin, NUM_COEFF=5: req=2'b11 in one cycle → channel 0 served, then channel 1. Two dout_vld pulses 9 cycles apart, ch_sel 0 then 1. A later req=2'b11 with rr_ptr=0 again serves channel 0 first.
- Overrun, NUM_COEFF=5: req[1] at cycles 3 and 4 while channel 0 is running → overrun=2'b10 and channel 1 is served once. ovr_clr pulse → overrun=0. ovr_clr coincident with a new overrun → overrun stays set.
- Reset mid-run: rst=1 at cycle 500 of RUN → sequencing=0 the next cycle, no dout_vld pulse, pending=0. A new req[1] afterwards is served normally.
- Grant/request collision, NUM_COEFF=5: req[0] pulsed in the same cycle the IDLE grant clears pending[0] → channel 0 is served twice consecutively and overrun=0.

Source files
------------

// File: rtl/fir_ch_sched_if.sv
// Bundles the request/result side and the core-control side of the FIR channel scheduler.
// The scheduler is the slave. The master side drives requests and the core result.
interface fir_ch_sched_if #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
);
  logic [NUM_CH-1:0]    req;
  logic [15:0]          core_out;
  logic                 ovr_clr;
  logic                 sequencing;
  logic [CH_W-1:0]      ch_sel;
  logic                 busy;
  logic [16*NUM_CH-1:0] dout;
  logic [NUM_CH-1:0]    dout_vld;
  logic [NUM_CH-1:0]    overrun;

  modport master (
    output req, core_out, ovr_clr,
    input  sequencing, ch_sel, busy, dout, dout_vld, overrun
  );

  modport slave (
    input  req, core_out, ovr_clr,
    output sequencing, ch_sel, busy, dout, dout_vld, overrun
  );
endinterface

// File: rtl/fir_ch_sched.sv
// Round-robin scheduler that time-shares one FIR MAC core across NUM_CH channels.
// Each grant opens a NUM_COEFF+1 cycle sequencing window, then waits one drain cycle and captures the result.
module fir_ch_sched #(
  parameter int NUM_COEFF = 1021,
  parameter int NUM_CH    = 2,
  parameter int CH_W      = 1,
  parameter int CNT_W     = 11
) (
  input logic           clk,
  input logic           rst,
  fir_ch_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CAPT} state_t;

  state_t               state, state_next;
  logic [NUM_CH-1:0]    pending, overrun_q, dout_vld_q;
  logic [NUM_CH-1:0]    grant_mask, overrun_set;
  logic [CH_W-1:0]      rr_ptr, ch_sel_q, grant_ch, idx;
  logic                 grant_vld, sequencing_q;
  logic [CNT_W-1:0]     cnt;
  logic [16*NUM_CH-1:0] dout_q;

  // Scan downward from the farthest offset so the channel nearest rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (pending[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = idx;
      end
    end
  end

  assign grant_mask  = (state == IDLE && grant_vld) ? (NUM_CH'(1) << grant_ch) : '0;
  assign overrun_set = bus.req & pending & ~grant_mask;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_vld) state_next = RUN;
      RUN:     if (cnt == CNT_W'(NUM_COEFF)) state_next = DRAIN;
      DRAIN:   state_next = CAPT;
      CAPT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A request arriving in the same cycle its pending bit is granted re-arms it without an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      overrun_q    <= '0;
      rr_ptr       <= '0;
      ch_sel_q     <= '0;
      cnt          <= '0;
      sequencing_q <= 1'b0;
      dout_q       <= '0;
      dout_vld_q   <= '0;
    end else begin
      pending      <= (pending & ~grant_mask) | bus.req;
      overrun_q    <= (bus.ovr_clr ? '0 : overrun_q) | overrun_set;
      sequencing_q <= (state_next == RUN);
      dout_vld_q   <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            ch_sel_q <= grant_ch;
            rr_ptr   <= CH_W'((int'(grant_ch) + 1) % NUM_CH);
            cnt      <= '0;
          end
        end
        RUN: begin
          if (cnt != CNT_W'(NUM_COEFF)) cnt <= cnt + CNT_W'(1);
        end
        CAPT: begin
          dout_q[16*ch_sel_q +: 16] <= bus.core_out;
          dout_vld_q                <= NUM_CH'(1) << ch_sel_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.sequencing = sequencing_q;
  assign bus.ch_sel     = ch_sel_q;
  assign bus.busy       = (state != IDLE);
  assign bus.dout       = dout_q;
  assign bus.dout_vld   = dout_vld_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_fir_ch_sched.sv
// Directed bench for fir_ch_sched: one instance at 1021 taps, one at 5 taps, selected through a shared driver/observer.
// Relative cycle i of each stimulus run is the cycle in which the scheduled inputs are applied.
module tb_fir_ch_sched;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [1:0]  req_drv;
  logic        clr_drv;
  logic [15:0] core_drv;

  int n_vec = 0;
  int n_bad = 0;

  fir_ch_sched_if #(.NUM_CH(2), .CH_W(1)) bus_a ();
  fir_ch_sched_if #(.NUM_CH(2), .CH_W(1)) bus_b ();

  fir_ch_sched #(.NUM_COEFF(1021), .NUM_CH(2), .CH_W(1), .CNT_W(11)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  fir_ch_sched #(.NUM_COEFF(5), .NUM_CH(2), .CH_W(1), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  assign bus_a.req      = sel ? 2'b00 : req_drv;
  assign bus_b.req      = sel ? req_drv : 2'b00;
  assign bus_a.ovr_clr  = sel ? 1'b0 : clr_drv;
  assign bus_b.ovr_clr  = sel ? clr_drv : 1'b0;
  assign bus_a.core_out = core_drv;
  assign bus_b.core_out = core_drv;

  logic        o_seq, o_busy, o_chsel;
  logic [1:0]  o_vld, o_ovr;
  logic [31:0] o_dout;

  assign o_seq   = sel ? bus_b.sequencing : bus_a.sequencing;
  assign o_busy  = sel ? bus_b.busy       : bus_a.busy;
  assign o_chsel = sel ? bus_b.ch_sel     : bus_a.ch_sel;
  assign o_vld   = sel ? bus_b.dout_vld   : bus_a.dout_vld;
  assign o_ovr   = sel ? bus_b.overrun    : bus_a.overrun;
  assign o_dout  = sel ? bus_b.dout       : bus_a.dout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          seq_first, seq_last, seq_cnt, busy_cnt, rise_n, vld_n, multi_vld, chsel_moves;
  int          rise_cyc [4];
  logic        rise_ch  [4];
  int          vld_cyc  [4];
  logic [1:0]  vld_val  [4];
  logic [31:0] vld_dout [4];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Bit i of r0/r1/clr drives that input in relative cycle i; outputs are observed 1 time unit after each edge.
  task automatic applyStimulus(input int ncyc, input logic [63:0] r0, input logic [63:0] r1,
                               input logic [63:0] clr, input int rst_at,
                               input logic [15:0] core_base, input bit ramp);
    logic prev_seq;
    logic run_ch;
    prev_seq = 1'b0;
    run_ch = 1'b0;
    seq_first = -1; seq_last = -1; seq_cnt = 0; busy_cnt = 0;
    rise_n = 0; vld_n = 0; multi_vld = 0; chsel_moves = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (o_seq) begin
        if (seq_first < 0) seq_first = i;
        seq_last = i;
        seq_cnt++;
        if (!prev_seq) begin
          if (rise_n < 4) begin
            rise_cyc[rise_n] = i;
            rise_ch[rise_n]  = o_chsel;
          end
          rise_n++;
          run_ch = o_chsel;
        end else if (o_chsel != run_ch) begin
          chsel_moves++;
        end
      end
      prev_seq = o_seq;
      if (o_busy) busy_cnt++;
      if (o_vld != 2'b00) begin
        if (vld_n < 4) begin
          vld_cyc[vld_n]  = i;
          vld_val[vld_n]  = o_vld;
          vld_dout[vld_n] = o_dout;
        end
        vld_n++;
        if (o_vld == 2'b11) multi_vld++;
      end
      req_drv[0] = (i < 64) && r0[i[5:0]];
      req_drv[1] = (i < 64) && r1[i[5:0]];
      clr_drv    = (i < 64) && clr[i[5:0]];
      rst        = (i == rst_at);
      core_drv   = ramp ? core_base + 16'(i) : core_base;
      @(posedge clk);
      #1;
    end
    req_drv = 2'b00;
    clr_drv = 1'b0;
    rst     = 1'b0;
  endtask

  initial begin
    sel = 1'b0; req_drv = 2'b00; clr_drv = 1'b0; core_drv = 16'h0000;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset then idle");
    applyStimulus(50, 64'h0, 64'h0, 64'h0, -1, 16'h0000, 1'b0);
    checkOutput("idle_seq_cnt", seq_cnt, 0);
    checkOutput("idle_busy_cnt", busy_cnt, 0);
    checkOutput("idle_vld_cnt", vld_n, 0);
    checkOutput("idle_dout_a", o_dout, 32'h0);
    checkOutput("idle_ovr_a", o_ovr, 2'b00);
    checkOutput("idle_chsel_a", o_chsel, 1'b0);
    sel = 1'b1;
    #1;
    checkOutput("idle_dout_b", o_dout, 32'h0);
    checkOutput("idle_seq_b", o_seq, 1'b0);
    sel = 1'b0;

    $display("[TB] single channel, 1021 taps");
    applyStimulus(1040, 64'h1, 64'h0, 64'h0, -1, 16'h1234, 1'b0);
    checkOutput("single_seq_first", seq_first, 2);
    checkOutput("single_seq_last", seq_last, 1023);
    checkOutput("single_seq_cnt", seq_cnt, 1022);
    checkOutput("single_busy_cnt", busy_cnt, 1024);
    checkOutput("single_rise_ch", rise_ch[0], 1'b0);
    checkOutput("single_chsel_moves", chsel_moves, 0);
    checkOutput("single_vld_cnt", vld_n, 1);
    checkOutput("single_vld_cyc", vld_cyc[0], 1026);
    checkOutput("single_vld_val", vld_val[0], 2'b01);
    checkOutput("single_dout", vld_dout[0], 32'h0000_1234);
    checkOutput("single_vld_end", o_vld, 2'b00);

    $display("[TB] round robin, 5 taps");
    sel = 1'b1;
    applyStimulus(40, 64'h1, 64'h1, 64'h0, -1, 16'hA000, 1'b1);
    checkOutput("rr_seq_cnt", seq_cnt, 12);
    checkOutput("rr_rise_n", rise_n, 2);
    checkOutput("rr_rise0_cyc", rise_cyc[0], 2);
    checkOutput("rr_rise0_ch", rise_ch[0], 1'b0);
    checkOutput("rr_rise1_cyc", rise_cyc[1], 11);
    checkOutput("rr_rise1_ch", rise_ch[1], 1'b1);
    checkOutput("rr_busy_cnt", busy_cnt, 16);
    checkOutput("rr_vld_cnt", vld_n, 2);
    checkOutput("rr_vld0_cyc", vld_cyc[0], 10);
    checkOutput("rr_vld1_cyc", vld_cyc[1], 19);
    checkOutput("rr_vld0_val", vld_val[0], 2'b01);
    checkOutput("rr_vld1_val", vld_val[1], 2'b10);
    checkOutput("rr_dout0", vld_dout[0], 32'h0000_A009);
    checkOutput("rr_dout1", vld_dout[1], 32'hA012_A009);
    checkOutput("rr_chsel_hold", o_chsel, 1'b1);
    checkOutput("rr_multi_vld", multi_vld, 0);

    applyStimulus(25, 64'h1, 64'h1, 64'h0, -1, 16'hB000, 1'b1);
    checkOutput("rr2_rise0_ch", rise_ch[0], 1'b0);
    checkOutput("rr2_rise1_ch", rise_ch[1], 1'b1);
    checkOutput("rr2_dout1", vld_dout[1], 32'hB012_B009);

    $display("[TB] overrun, 5 taps");
    applyStimulus(30, 64'h1, 64'h18, 64'h0, -1, 16'hC000, 1'b1);
    checkOutput("ovr_rise_n", rise_n, 2);
    checkOutput("ovr_rise1_cyc", rise_cyc[1], 11);
    checkOutput("ovr_rise1_ch", rise_ch[1], 1'b1);
    checkOutput("ovr_vld_cnt", vld_n, 2);
    checkOutput("ovr_flag", o_ovr, 2'b10);
    applyStimulus(3, 64'h0, 64'h0, 64'h1, -1, 16'h0000, 1'b0);
    checkOutput("ovr_clr", o_ovr, 2'b00);
    applyStimulus(30, 64'h1, 64'h18, 64'h10, -1, 16'hD000, 1'b1);
    checkOutput("ovr_set_wins", o_ovr, 2'b10);
    applyStimulus(3, 64'h0, 64'h0, 64'h1, -1, 16'h0000, 1'b0);
    checkOutput("ovr_clr2", o_ovr, 2'b00);

    $display("[TB] grant/request collision, 5 taps");
    applyStimulus(30, 64'h3, 64'h0, 64'h0, -1, 16'hE000, 1'b1);
    checkOutput("coll_rise_n", rise_n, 2);
    checkOutput("coll_rise1_cyc", rise_cyc[1], 11);
    checkOutput("coll_rise0_ch", rise_ch[0], 1'b0);
    checkOutput("coll_rise1_ch", rise_ch[1], 1'b0);
    checkOutput("coll_vld1_val", vld_val[1], 2'b01);
    checkOutput("coll_dout1", vld_dout[1], 32'hD012_E012);
    checkOutput("coll_ovr", o_ovr, 2'b00);

    $display("[TB] reset mid-run, 1021 taps");
    sel = 1'b0;
    applyStimulus(600, 64'h1, 64'h20, 64'h0, 501, 16'h1234, 1'b0);
    checkOutput("mrst_seq_last", seq_last, 501);
    checkOutput("mrst_seq_cnt", seq_cnt, 500);
    checkOutput("mrst_vld_cnt", vld_n, 0);
    checkOutput("mrst_busy", o_busy, 1'b0);
    applyStimulus(20, 64'h0, 64'h0, 64'h0, -1, 16'h0000, 1'b0);
    checkOutput("mrst_pending_gone", seq_cnt, 0);
    checkOutput("mrst_dout", o_dout, 32'h0);
    applyStimulus(1040, 64'h0, 64'h1, 64'h0, -1, 16'h5678, 1'b0);
    checkOutput("mrst_next_first", seq_first, 2);
    checkOutput("mrst_next_cnt", seq_cnt, 1022);
    checkOutput("mrst_next_ch", rise_ch[0], 1'b1);
    checkOutput("mrst_next_vld_cyc", vld_cyc[0], 1026);
    checkOutput("mrst_next_vld_val", vld_val[0], 2'b10);
    checkOutput("mrst_next_dout", vld_dout[0], 32'h5678_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
